exwb_wb_arb: RTL and testbench

Parametrised EX->WB stage between NUM_EX execution channels and NUM_WB ROB writeback ports. Each channel gets a small FIFO so producers (ALU, forwarder, LSU, MUL, ...) can complete in the same cycle. A round-robin arbiter picks up to NUM_WB heads per cycle and registers them onto the ROB writeback ports as tag/result pairs. Invalid ports carry TAG_INVALID. Supersedes the fixed two-channel EX/WB register.

---
 rtl/exwb_pkg.sv | 57 +++++
 rtl/exwb_chan_fifo.sv | 73 +++++++
 rtl/exwb_wb_arb.sv | 163 ++++++++++++++++
 tb/tb_exwb_wb_arb.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exwb_pkg.sv
// exwb_pkg: shared types and helpers for the EX->WB writeback arbiter.
//   DATA_W_DEF / TAG_W_DEF : default result and ROB tag widths
//   TAG_INVALID            : all-ones tag marking an empty writeback port
//   wb_entry_t             : {tag, result} pair at the default widths
//   rr_pick()              : round-robin selection of up to num_wb
//                            non-empty channels, starting at ptr
package exwb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 6;
    localparam logic [TAG_W_DEF-1:0] TAG_INVALID = '1;

    // Upper bound on channels the picker can handle; IDX_W covers both
    // channel indices and port indices.
    localparam int MAX_EX = 16;
    localparam int IDX_W  = 4;

    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] result;
    } wb_entry_t;

    typedef struct packed {
        logic [MAX_EX-1:0]            grant; // channel c pops this cycle
        logic [MAX_EX-1:0][IDX_W-1:0] port;  // port assigned to channel c
        logic [IDX_W-1:0]             last;  // last channel granted
        logic                         any;   // at least one grant
    } rr_pick_t;

    // Scan channels ptr, ptr+1, ... (wrapping at num_ex). The k-th
    // non-empty channel found gets port k while k < num_wb.
    function automatic rr_pick_t rr_pick(input logic [MAX_EX-1:0] nonempty,
                                         input int num_ex,
                                         input int num_wb,
                                         input int ptr);
        rr_pick_t r;
        int       k;
        int       idx;
        r = '0;
        k = 0;
        for (int i = 0; i < MAX_EX; i++) begin
            if (i < num_ex) begin
                idx = ptr + i;
                if (idx >= num_ex) idx = idx - num_ex;
                if (nonempty[idx] && (k < num_wb)) begin
                    r.grant[idx] = 1'b1;
                    r.port[idx]  = IDX_W'(k);
                    r.last       = IDX_W'(idx);
                    r.any        = 1'b1;
                    k            = k + 1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/exwb_chan_fifo.sv
// exwb_chan_fifo: small per-channel FIFO feeding the writeback arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write din (ignored when full)
//   pop      : drop head (ignored when empty)
//   flush    : synchronous clear, overrides push and pop
//   din      : entry to write
//   full     : registered count == BUF_DEPTH (no same-cycle pass-through)
//   empty    : registered count == 0
//   head     : oldest entry, valid while !empty
module exwb_chan_fifo
    import exwb_pkg::*;
#(
    parameter int  BUF_DEPTH = 2,
    parameter type entry_t   = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t din,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    entry_t        mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(BUF_DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    assign full    = (count == CW'(BUF_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries behind valid pointers are read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/exwb_wb_arb.sv
// exwb_wb_arb: EX->WB stage between NUM_EX execution channels and NUM_WB
// ROB writeback ports. Each channel is buffered in a BUF_DEPTH FIFO; a
// round-robin arbiter grants up to NUM_WB FIFO heads per cycle and
// registers them onto the writeback ports.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : synchronous pipeline flush (drops all buffered entries)
//   ex_valid  : per channel, a result is presented
//   ex_tag    : per channel ROB tag (TAG_W each)
//   ex_result : per channel result (DATA_W each)
//   ex_ready  : per channel, FIFO can accept
//   wb_valid  : per port, a result is written back this cycle
//   wb_tag    : per port tag, all-ones when the port is idle
//   wb_result : per port result (holds old value when idle)
//   stall_cnt : (EXWB_PERF_CNT_EN only) per channel 16-bit saturating
//               count of cycles with ex_valid & ~ex_ready
//
// Handshake: a channel transfer happens at a clock edge where ex_valid
// and ex_ready are both high. ex_ready depends only on the registered
// FIFO count, so it never combinationally depends on ex_valid. The ROB
// side has no ready: every wb_valid beat is consumed in its cycle.
module exwb_wb_arb
    import exwb_pkg::*;
#(
    parameter int NUM_EX    = 4,
    parameter int NUM_WB    = 2,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TAG_W     = TAG_W_DEF,
    parameter int BUF_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_EX-1:0]        ex_valid,
    input  logic [NUM_EX*TAG_W-1:0]  ex_tag,
    input  logic [NUM_EX*DATA_W-1:0] ex_result,
    output logic [NUM_EX-1:0]        ex_ready,
    output logic [NUM_WB-1:0]        wb_valid,
    output logic [NUM_WB*TAG_W-1:0]  wb_tag,
    output logic [NUM_WB*DATA_W-1:0] wb_result
`ifdef EXWB_PERF_CNT_EN
    ,
    output logic [NUM_EX*16-1:0]     stall_cnt
`endif
);

    localparam int CHW = (NUM_EX > 1) ? $clog2(NUM_EX) : 1;
    localparam logic [TAG_W-1:0] TAG_INV = '1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] result;
    } entry_t;

    entry_t            din       [NUM_EX];
    entry_t            head      [NUM_EX];
    logic [NUM_EX-1:0] full;
    logic [NUM_EX-1:0] empty;
    logic [NUM_EX-1:0] push;
    logic [NUM_EX-1:0] pop;

    logic [CHW-1:0]    rr_ptr;
    logic [MAX_EX-1:0] nonempty_ext;
    rr_pick_t          pick;
    logic              pick_unused;

    entry_t            sel_entry [NUM_WB];
    logic [NUM_WB-1:0] sel_valid;

    assign ex_ready = ~full;
    assign push     = ex_valid & ex_ready;
    assign pop      = pick.grant[NUM_EX-1:0];

    for (genvar i = 0; i < NUM_EX; i++) begin : g_chan
        assign din[i] = '{tag:    ex_tag[i*TAG_W +: TAG_W],
                          result: ex_result[i*DATA_W +: DATA_W]};

        exwb_chan_fifo #(
            .BUF_DEPTH (BUF_DEPTH),
            .entry_t   (entry_t)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop[i]),
            .flush (flush),
            .din   (din[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    always_comb begin
        nonempty_ext               = '0;
        nonempty_ext[NUM_EX-1:0]   = ~empty;
        pick = rr_pick(nonempty_ext, NUM_EX, NUM_WB, int'(rr_ptr));
    end

    // Channels beyond NUM_EX leave picker bits that are always zero.
    assign pick_unused = ^{pick, nonempty_ext};

    // Route each granted head to the port the picker assigned it.
    always_comb begin
        for (int k = 0; k < NUM_WB; k++) begin
            sel_valid[k] = 1'b0;
            sel_entry[k] = '0;
            for (int c = 0; c < NUM_EX; c++) begin
                if (pick.grant[c] && (int'(pick.port[c]) == k)) begin
                    sel_valid[k] = 1'b1;
                    sel_entry[k] = head[c];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (flush) begin
            rr_ptr <= '0;
        end else if (pick.any) begin
            if (int'(pick.last) == NUM_EX - 1) rr_ptr <= '0;
            else                               rr_ptr <= CHW'(pick.last) + CHW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid  <= '0;
            wb_tag    <= '1;
            wb_result <= '0;
        end else if (flush) begin
            wb_valid  <= '0;
            wb_tag    <= '1;
        end else begin
            for (int k = 0; k < NUM_WB; k++) begin
                wb_valid[k] <= sel_valid[k];
                if (sel_valid[k]) begin
                    wb_tag[k*TAG_W +: TAG_W]     <= sel_entry[k].tag;
                    wb_result[k*DATA_W +: DATA_W] <= sel_entry[k].result;
                end else begin
                    wb_tag[k*TAG_W +: TAG_W]     <= TAG_INV;
                end
            end
        end
    end

`ifdef EXWB_PERF_CNT_EN
    // Stall counters survive flush; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_EX; i++) begin
                if (ex_valid[i] && !ex_ready[i] &&
                    (stall_cnt[i*16 +: 16] != 16'hFFFF))
                    stall_cnt[i*16 +: 16] <= stall_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_exwb_wb_arb.sv
// tb_exwb_wb_arb: self-checking bench for exwb_wb_arb (default parameters).
// A queue-based reference model predicts writeback ports, ex_ready and
// (with EXWB_PERF_CNT_EN) stall counters; a compare process checks them on
// every falling edge, and directed literal checks pin the model.
module tb_exwb_wb_arb;

    localparam int NE = 4;
    localparam int NW = 2;
    localparam int DW = 32;
    localparam int TW = 6;
    localparam int BD = 2;
    localparam logic [TW-1:0] TINV = '1;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [NE-1:0]    ex_valid;
    logic [NE*TW-1:0] ex_tag;
    logic [NE*DW-1:0] ex_result;
    logic [NE-1:0]    ex_ready;
    logic [NW-1:0]    wb_valid;
    logic [NW*TW-1:0] wb_tag;
    logic [NW*DW-1:0] wb_result;
`ifdef EXWB_PERF_CNT_EN
    logic [NE*16-1:0] stall_cnt;
`endif

    exwb_wb_arb #(
        .NUM_EX(NE), .NUM_WB(NW), .DATA_W(DW), .TAG_W(TW), .BUF_DEPTH(BD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_tag    (ex_tag),
        .ex_result (ex_result),
        .ex_ready  (ex_ready),
        .wb_valid  (wb_valid),
        .wb_tag    (wb_tag),
        .wb_result (wb_result)
`ifdef EXWB_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [TW-1:0] exp_q[$];   // tags accepted and not yet written back

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_cnt [NE];
    logic [TW-1:0] m_tag [NE][BD];
    logic [DW-1:0] m_res [NE][BD];
    int            m_rr;
    int            m_stall [NE];
    logic [NW-1:0] e_valid;
    logic [TW-1:0] e_tag [NW];
    logic [DW-1:0] e_res [NW];

    task automatic model_reset();
        for (int c = 0; c < NE; c++) begin
            m_cnt[c]   = 0;
            m_stall[c] = 0;
        end
        m_rr    = 0;
        e_valid = '0;
        for (int k = 0; k < NW; k++) begin
            e_tag[k] = TINV;
            e_res[k] = '0;
        end
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [NE-1:0] rdy;
        int k;
        int ch;
        int last;
        for (int c = 0; c < NE; c++) rdy[c] = (m_cnt[c] < BD);
        for (int c = 0; c < NE; c++)
            if (ex_valid[c] && !rdy[c] && m_stall[c] < 65535) m_stall[c]++;
        if (flush) begin
            for (int c = 0; c < NE; c++) m_cnt[c] = 0;
            m_rr    = 0;
            e_valid = '0;
            for (int p = 0; p < NW; p++) e_tag[p] = TINV;
            exp_q.delete();
            return;
        end
        k       = 0;
        last    = 0;
        e_valid = '0;
        for (int i = 0; i < NE; i++) begin
            ch = (m_rr + i) % NE;
            if (m_cnt[ch] > 0 && k < NW) begin
                e_valid[k] = 1'b1;
                e_tag[k]   = m_tag[ch][0];
                e_res[k]   = m_res[ch][0];
                for (int j = 0; j < BD - 1; j++) begin
                    m_tag[ch][j] = m_tag[ch][j+1];
                    m_res[ch][j] = m_res[ch][j+1];
                end
                m_cnt[ch]--;
                last = ch;
                k++;
            end
        end
        for (int p = k; p < NW; p++) e_tag[p] = TINV;
        if (k > 0) m_rr = (last + 1) % NE;
        for (int c = 0; c < NE; c++) begin
            if (ex_valid[c] && rdy[c]) begin
                m_tag[c][m_cnt[c]] = ex_tag[c*TW +: TW];
                m_res[c][m_cnt[c]] = ex_result[c*DW +: DW];
                m_cnt[c]++;
                exp_q.push_back(ex_tag[c*TW +: TW]);
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ---------------- compare process ----------------
    task automatic sb_remove(input logic [TW-1:0] t);
        int idx;
        idx = -1;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i] == t) idx = i;
        check($sformatf("sb_tag_known(0x%0h)", t), (idx >= 0), 1'b1);
        if (idx >= 0) exp_q.delete(idx);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NW; k++) begin
                check($sformatf("wb_valid[%0d]", k), wb_valid[k], e_valid[k]);
                check($sformatf("wb_tag[%0d]", k), wb_tag[k*TW +: TW], e_tag[k]);
                if (e_valid[k])
                    check($sformatf("wb_result[%0d]", k),
                          wb_result[k*DW +: DW], e_res[k]);
                if (wb_valid[k]) sb_remove(wb_tag[k*TW +: TW]);
            end
            for (int c = 0; c < NE; c++)
                check($sformatf("ex_ready[%0d]", c), ex_ready[c], (m_cnt[c] < BD));
`ifdef EXWB_PERF_CNT_EN
            for (int c = 0; c < NE; c++)
                check($sformatf("stall_cnt[%0d]", c), stall_cnt[c*16 +: 16],
                      64'(m_stall[c]));
`endif
        end
    end

    // Illegal stimulus guard: a valid channel must never carry TAG_INVALID.
    always @(posedge clk) begin
        for (int c = 0; c < NE; c++)
            if (!rst && ex_valid[c])
                assert (ex_tag[c*TW +: TW] != TINV) else $error("illegal tag on channel %0d", c);
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [NE-1:0] v, input logic [NE*TW-1:0] t,
                         input logic [NE*DW-1:0] r, input logic fl);
        ex_valid  = v;
        ex_tag    = t;
        ex_result = r;
        flush     = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive('0, '0, '0, 1'b0);
    endtask

    task automatic do_flush();
        drive('0, '0, '0, 1'b1);
    endtask

    task automatic stream_cycle(input int base, input int c);
        logic [NE*TW-1:0] t;
        logic [NE*DW-1:0] r;
        for (int ch = 0; ch < NE; ch++) begin
            t[ch*TW +: TW] = TW'(base + c*4 + ch);
            r[ch*DW +: DW] = $urandom_range(32'hFFFF_FFFF, 0);
        end
        drive({NE{1'b1}}, t, r, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        ex_valid  = '0;
        ex_tag    = '0;
        ex_result = '0;
        #1 rst = 1'b1;
        #2;
        // Reset is asynchronous: no clock edge has happened yet.
        check("rst_wb_valid", wb_valid, '0);
        check("rst_wb_tag", wb_tag, {NW*TW{1'b1}});
        check("rst_wb_result", wb_result, '0);
        check("rst_ex_ready", ex_ready, 4'hF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Single result on ch0: visible on port 0 two edges later.
        drive(4'b0001, {6'd0, 6'd0, 6'd0, 6'd5},
              {32'd0, 32'd0, 32'd0, 32'hDEAD_BEEF}, 1'b0);
        idle();
        check("t1_wb_valid", wb_valid, 2'b01);
        check("t1_tag0", wb_tag[TW-1:0], 6'd5);
        check("t1_res0", wb_result[DW-1:0], 32'hDEAD_BEEF);
        check("t1_tag1", wb_tag[2*TW-1:TW], TINV);

        // Four channels at once from rr_ptr 0.
        do_flush();
        drive(4'hF, {6'd4, 6'd3, 6'd2, 6'd1},
              {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
        idle();
        check("t2a_wb_valid", wb_valid, 2'b11);
        check("t2a_tag0", wb_tag[TW-1:0], 6'd1);
        check("t2a_tag1", wb_tag[2*TW-1:TW], 6'd2);
        idle();
        check("t2b_tag0", wb_tag[TW-1:0], 6'd3);
        check("t2b_tag1", wb_tag[2*TW-1:TW], 6'd4);
        // rr_ptr back at 0: ch0 must beat ch3 for port 0.
        idle();
        drive(4'b1001, {6'd10, 6'd0, 6'd0, 6'd9},
              {32'hA, 32'd0, 32'd0, 32'h9}, 1'b0);
        idle();
        check("t2c_tag0_ch0", wb_tag[TW-1:0], 6'd9);
        check("t2c_tag1_ch3", wb_tag[2*TW-1:TW], 6'd10);

        // Sustained traffic on all channels for 6 cycles.
        do_flush();
        for (int c = 0; c < 6; c++) begin
            stream_cycle(8, c);
            if (c == 1) check("t3_ready_after_fill", ex_ready, 4'b0011);
            if (c >= 1) check($sformatf("t3_two_wb_c%0d", c), wb_valid, 2'b11);
        end
        for (int i = 0; i < 6; i++) idle();
        #1;
        check("t3_sb_drained", exp_q.size(), 0);
        check("t3_idle_valid", wb_valid, 2'b00);

        // Flush with three buffered entries and a concurrent ch1 push.
        @(negedge clk);
        do_flush();
        drive(4'b1101, {6'd42, 6'd41, 6'd0, 6'd40},
              {32'h42, 32'h41, 32'd0, 32'h40}, 1'b0);
        drive(4'b0010, {6'd0, 6'd0, 6'd43, 6'd0},
              {32'd0, 32'd0, 32'h43, 32'd0}, 1'b1);
        check("t4_wb_valid", wb_valid, 2'b00);
        check("t4_wb_tag", wb_tag, {NW*TW{1'b1}});
        check("t4_ex_ready", ex_ready, 4'hF);
        for (int i = 0; i < 3; i++) idle();
        #1;
        check("t4_sb_empty", exp_q.size(), 0);

        // Asynchronous reset while both ports are busy.
        @(negedge clk);
        do_flush();
        drive(4'hF, {6'd23, 6'd22, 6'd21, 6'd20},
              {32'h23, 32'h22, 32'h21, 32'h20}, 1'b0);
        idle();
        check("t5_busy", wb_valid, 2'b11);
        #2 rst = 1'b1;
        #1;
        check("t5_async_valid", wb_valid, 2'b00);
        check("t5_async_tag", wb_tag, {NW*TW{1'b1}});
        check("t5_async_ready", ex_ready, 4'hF);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0100, {6'd0, 6'd7, 6'd0, 6'd0},
              {32'd0, 32'h1234, 32'd0, 32'd0}, 1'b0);
        idle();
        check("t5_resume_valid", wb_valid, 2'b01);
        check("t5_resume_tag", wb_tag[TW-1:0], 6'd7);
        check("t5_resume_res", wb_result[DW-1:0], 32'h1234);

`ifdef EXWB_PERF_CNT_EN
        // Stall counters: from empty, full channels alternate pairs, so
        // over 11 streaming edges ch2/ch3 stall 5 times and ch0/ch1 4 times.
        idle();
        #2 rst = 1'b1;
        #1;
        check("t6_rst_cnt", stall_cnt, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 11; c++) stream_cycle(0, c);
        idle();
        check("t6_stall0", stall_cnt[15:0], 16'd4);
        check("t6_stall1", stall_cnt[31:16], 16'd4);
        check("t6_stall2", stall_cnt[47:32], 16'd5);
        check("t6_stall3", stall_cnt[63:48], 16'd5);
        do_flush();
        idle();
        check("t6_flush_keeps", stall_cnt[47:32], 16'd5);
`endif

        for (int i = 0; i < 4; i++) idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
